// File: rtl/router_rr.sv
// router_rr: 5-port XY-routed mesh router with per-input FIFOs and round-robin output arbitration
module router_rr #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 4,
  parameter int COORD_BITS = 2,
  parameter int ROUTER_X   = 0,
  parameter int ROUTER_Y   = 0,
  parameter int ACT_HOLD   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         in_valid,
  output logic [4:0]         in_ready,
  input  logic [5*WIDTH-1:0] in_data,
  output logic [4:0]         out_valid,
  input  logic [4:0]         out_ready,
  output logic [5*WIDTH-1:0] out_data,
  output logic [2:0]         activity_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [COORD_BITS-1:0] RX = COORD_BITS'(ROUTER_X);
  localparam logic [COORD_BITS-1:0] RY = COORD_BITS'(ROUTER_Y);

  logic [WIDTH-1:0] mem_q [5][DEPTH];
  logic [WIDTH-1:0] mem_d [5][DEPTH];
  logic [AW-1:0]    rd_q [5], rd_d [5], wr_q [5], wr_d [5];
  logic [AW:0]      cnt_q [5], cnt_d [5];
  logic [4:0]       ovld_q, ovld_d;
  logic [WIDTH-1:0] odata_q [5], odata_d [5];
  logic [2:0]       ptr_q [5], ptr_d [5];
  logic [3:0]       act_q [5], act_d [5];
  logic [4:0]       req [5];
  logic [4:0]       push, pop, xfer, active;

  function automatic logic [4:0] route(input logic [WIDTH-1:0] f);
    logic [COORD_BITS-1:0] dx, dy;
    dx = f[2*COORD_BITS-1:COORD_BITS];
    dy = f[COORD_BITS-1:0];
    return dx > RX ? 5'b00100 : dx < RX ? 5'b01000 : dy > RY ? 5'b00010 : dy < RY ? 5'b00001 : 5'b10000;
  endfunction

  // Handshakes, head-flit requests and port-level outputs
  always_comb begin
    activity_level = '0;
    out_valid = ovld_q;
    for (int i = 0; i < 5; i++) begin
      in_ready[i] = cnt_q[i] != (AW+1)'(DEPTH) && !reset;
      push[i] = in_valid[i] && in_ready[i];
      req[i] = cnt_q[i] != '0 ? route(mem_q[i][rd_q[i]]) : '0;
      xfer[i] = ovld_q[i] && out_ready[i];
      active[i] = !reset && (xfer[i] || act_q[i] != '0);
      activity_level = activity_level + 3'(active[i]);
      out_data[i*WIDTH +: WIDTH] = odata_q[i];
    end
  end

  // Round-robin grant per output, output register load, activity counters and FIFO pointers
  always_comb begin
    logic       found;
    logic [2:0] win, idx;
    logic [3:0] s;
    mem_d = mem_q;
    rd_d = rd_q;
    wr_d = wr_q;
    cnt_d = cnt_q;
    ovld_d = ovld_q;
    odata_d = odata_q;
    ptr_d = ptr_q;
    act_d = act_q;
    pop = '0;
    found = 1'b0;
    win = '0;
    idx = '0;
    s = '0;
    for (int o = 0; o < 5; o++) begin
      found = 1'b0;
      win = '0;
      for (int k = 0; k < 5; k++) begin
        s = {1'b0, ptr_q[o]} + 4'(k);
        idx = s > 4'd4 ? 3'(s - 4'd5) : s[2:0];
        if (!found && req[idx][o]) begin
          found = 1'b1;
          win = idx;
        end
      end
      found = found && (!ovld_q[o] || out_ready[o]);
      if (found) begin
        odata_d[o] = mem_q[win][rd_q[win]];
        ovld_d[o] = 1'b1;
        ptr_d[o] = win == 3'd4 ? 3'd0 : win + 3'd1;
        pop[win] = 1'b1;
      end else if (xfer[o]) ovld_d[o] = 1'b0;
      act_d[o] = xfer[o] ? 4'(ACT_HOLD) : act_q[o] != '0 ? act_q[o] - 4'd1 : act_q[o];
    end
    for (int i = 0; i < 5; i++) begin
      if (push[i]) begin
        mem_d[i][wr_q[i]] = in_data[i*WIDTH +: WIDTH];
        wr_d[i] = wr_q[i] + AW'(1);
      end
      if (pop[i]) rd_d[i] = rd_q[i] + AW'(1);
      cnt_d[i] = cnt_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '{default: '0};
      wr_q <= '{default: '0};
      cnt_q <= '{default: '0};
      ovld_q <= '0;
      odata_q <= '{default: '0};
      ptr_q <= '{default: '0};
      act_q <= '{default: '0};
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      ovld_q <= ovld_d;
      odata_q <= odata_d;
      ptr_q <= ptr_d;
      act_q <= act_d;
    end
  end

  // FIFO storage; occupancy alone decides what is valid, so no reset is needed
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_router_rr.sv
// tb_router_rr: scoreboard bench for router_rr with randomized and directed traffic
module tb_router_rr;
  localparam int W = 16, RX = 1, RY = 1, HOLD = 3;

  logic           clk = 0, reset = 1;
  logic [4:0]     in_valid = '0, in_ready, out_valid, out_ready = '0;
  logic [5*W-1:0] in_data = '0, out_data;
  logic [2:0]     activity_level;

  int checks = 0, errors = 0;
  logic [15:0] exp_q [25][$];
  int log4[$], cyc4[$];
  int xcnt[5] = '{default: 0};
  int last_x[5] = '{default: -100};
  int cyc = 0, seq = 0;
  logic [15:0] cap_d, md, e;
  int src, act_exp;
  logic xf;

  router_rr #(.WIDTH(W), .DEPTH(4), .COORD_BITS(2), .ROUTER_X(RX), .ROUTER_Y(RY), .ACT_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .activity_level(activity_level)
  );

  always #5 clk = ~clk;

  function automatic int dir_of(int dx, int dy);
    if (dx > RX) return 2;
    if (dx < RX) return 3;
    if (dy > RY) return 1;
    if (dy < RY) return 0;
    return 4;
  endfunction

  function automatic logic [15:0] mk(int i, int dx, int dy);
    seq++;
    return {9'(seq), 3'(i), 2'(dx), 2'(dy)};
  endfunction

  function automatic int pending();
    int t = 0;
    for (int k = 0; k < 25; k++) t += exp_q[k].size();
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  // Stimulus side of the scoreboard: every accepted flit is expected at its XY output
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < 25; k++) exp_q[k].delete();
    end else begin
      for (int i = 0; i < 5; i++)
        if (in_valid[i] && in_ready[i]) begin
          cap_d = in_data[i*W +: W];
          exp_q[i*5 + dir_of(int'(cap_d[3:2]), int'(cap_d[1:0]))].push_back(cap_d);
        end
    end
  end

  // Monitor: checks every output transfer and the activity level every cycle
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      for (int o = 0; o < 5; o++) last_x[o] = -100;
      checks++;
      if (in_ready !== 5'b0 || activity_level !== 3'd0) begin
        errors++;
        $display("FAIL reset_outputs in_ready=%b act=%0d want 0 0", in_ready, activity_level);
      end
    end else begin
      act_exp = 0;
      for (int o = 0; o < 5; o++) begin
        xf = out_valid[o] && out_ready[o];
        if (xf || (cyc - last_x[o] <= HOLD)) act_exp++;
        if (xf) begin
          last_x[o] = cyc;
          xcnt[o]++;
          md = out_data[o*W +: W];
          src = int'(md[6:4]);
          checks++;
          if (src > 4 || exp_q[src*5 + o].size() == 0) begin
            errors++;
            $display("FAIL out%0d_unexpected got %h want none", o, md);
          end else begin
            e = exp_q[src*5 + o].pop_front();
            if (md !== e) begin
              errors++;
              $display("FAIL out%0d_data got %h want %h", o, md, e);
            end
          end
          if (o == 4) begin
            log4.push_back(src);
            cyc4.push_back(cyc);
          end
        end
      end
      checks++;
      if (int'(activity_level) != act_exp) begin
        errors++;
        $display("FAIL activity_level got %0d want %0d", activity_level, act_exp);
      end
    end
  end

  // kind 0: random traffic and random backpressure; kind 1: all inputs saturate the local port
  task automatic cycle_drive(input int n, input int kind);
    logic [4:0] acc;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      if (kind == 0) out_ready = 5'($urandom);
      for (int i = 0; i < 5; i++)
        if (!in_valid[i] || acc[i]) begin
          if (kind == 1) begin
            in_valid[i] = 1'b1;
            in_data[i*W +: W] = mk(i, RX, RY);
          end else begin
            in_valid[i] = 1'($urandom);
            in_data[i*W +: W] = mk(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
          end
        end
    end
  endtask

  task automatic drain();
    in_valid = '0;
    out_ready = 5'h1f;
    for (int k = 0; k < 300 && pending() != 0; k++) @(negedge clk);
    repeat (HOLD + 2) @(negedge clk);
    chk("drain_pending", pending(), 0);
  endtask

  task automatic stream(input int p, input int dx, input int dy, input int total, input int cycles, inout int n);
    logic a;
    for (int k = 0; k < cycles && n < total; k++) begin
      @(negedge clk);
      a = in_valid[p] && in_ready[p];
      if (a) n++;
      @(posedge clk);
      #1;
      if (a) begin
        if (n < total) in_data[p*W +: W] = mk(p, dx, dy);
        else in_valid[p] = 1'b0;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b[5];
    int dxs[4] = '{2, 0, 1, 1};
    int dys[4] = '{0, 3, 2, 0};
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("post_reset_out_valid", out_valid, 0);

    // local delivery and two-cycle latency
    @(posedge clk);
    #1;
    out_ready = 5'h1f;
    in_valid[0] = 1'b1;
    in_data[0 +: W] = 16'h0005;
    @(negedge clk);
    chk("local_in_ready", in_ready[0], 1);
    @(posedge clk);
    #1;
    in_valid = '0;
    @(negedge clk);
    chk("latency_not_early", out_valid, 0);
    @(negedge clk);
    chk("local_out_valid", out_valid, 5'b10000);
    chk("local_out_data", out_data[4*W +: W], 16'h0005);
    drain();

    // XY direction from the local input
    for (int o = 0; o < 5; o++) b[o] = xcnt[o];
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      in_valid[4] = 1'b1;
      in_data[4*W +: W] = mk(4, dxs[k], dys[k]);
      @(posedge clk);
      #1;
    end
    drain();
    for (int o = 0; o < 5; o++) chk($sformatf("xy_count_out%0d", o), xcnt[o] - b[o], o == 4 ? 0 : 1);

    // activity hold after a single east transfer, then two concurrent outputs
    @(posedge clk);
    #1;
    in_valid[4] = 1'b1;
    in_data[4*W +: W] = mk(4, 2, 0);
    @(posedge clk);
    #1;
    in_valid = '0;
    for (int k = 0; k < 10 && !out_valid[2]; k++) @(negedge clk);
    chk("act_east_valid", out_valid[2], 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("act_hold_%0d", k), activity_level, k < 4 ? 1 : 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 5'b00011;
    in_data[0 +: W] = mk(0, 2, 0);
    in_data[W +: W] = mk(1, 0, 1);
    @(posedge clk);
    #1;
    in_valid = '0;
    for (int k = 0; k < 10 && !out_valid[2]; k++) @(negedge clk);
    chk("act_two_valid", out_valid & 5'b01100, 5'b01100);
    chk("act_two_level", activity_level, 2);
    drain();

    // backpressure on east with a stream from the west input
    @(posedge clk);
    #1;
    out_ready = 5'h1b;
    n = 0;
    in_valid[3] = 1'b1;
    in_data[3*W +: W] = mk(3, 2, 1);
    stream(3, 2, 1, 6, 12, n);
    chk("bp_accepted", n, 5);
    @(negedge clk);
    chk("bp_in_ready_low", in_ready[3], 0);
    @(posedge clk);
    #1;
    out_ready = 5'h1f;
    stream(3, 2, 1, 6, 20, n);
    chk("bp_total", n, 6);
    drain();

    // reset in the middle of buffered traffic
    @(posedge clk);
    #1;
    out_ready = '0;
    n = 0;
    in_valid[1] = 1'b1;
    in_data[W +: W] = mk(1, 1, 0);
    stream(1, 1, 0, 4, 10, n);
    repeat (2) @(negedge clk);
    chk("rst_pre_valid", out_valid[0], 1);
    for (int o = 0; o < 5; o++) b[o] = xcnt[o];
    @(posedge clk);
    #1;
    reset = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_activity", activity_level, 0);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    reset = 0;
    out_ready = 5'h1f;
    @(negedge clk);
    chk("rst_first_cycle_idle", out_valid, 0);
    repeat (10) @(negedge clk);
    chk("rst_no_stale", xcnt[0] + xcnt[1] + xcnt[2] + xcnt[3] + xcnt[4] - b[0] - b[1] - b[2] - b[3] - b[4], 0);

    // saturated contention on the local output
    log4.delete();
    cyc4.delete();
    out_ready = 5'h1f;
    cycle_drive(60, 1);
    drain();
    chk("rr_enough", log4.size() >= 50, 1);
    for (int k = 0; k < 40 && k < log4.size(); k++) chk($sformatf("rr_order_%0d", k), log4[k], k % 5);
    for (int k = 1; k < 40 && k < cyc4.size(); k++) chk($sformatf("rr_rate_%0d", k), cyc4[k] - cyc4[k-1], 1);

    // random traffic with random backpressure
    cycle_drive(1500, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
